// File: rtl/spi_command_processor.sv
// SPI byte command parser bridging to the coax word paths and a control register.
// Optional build macro COMMAND_LOOPBACK_EN adds the control[7] internal loopback buffer.
module spi_command_processor #(
  parameter logic [7:0] VERSION         = 8'h01,
  parameter logic [7:0] CONTROL_DEFAULT = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_cs,
  input  logic [7:0] spi_rx_data,
  input  logic       spi_rx_strobe,
  output logic [7:0] spi_tx_data,
  output logic       spi_tx_strobe,
  output logic [9:0] coax_tx_data,
  output logic       coax_tx_valid,
  input  logic       coax_tx_ready,
  input  logic [9:0] coax_rx_data,
  input  logic       coax_rx_valid,
  output logic       coax_rx_ready,
  output logic [7:0] control
);

  localparam logic [2:0] ST_COMMAND    = 3'd0;
  localparam logic [2:0] ST_WR_CONTROL = 3'd1;
  localparam logic [2:0] ST_TX_HIGH    = 3'd2;
  localparam logic [2:0] ST_TX_LOW     = 3'd3;
  localparam logic [2:0] ST_RX_HIGH    = 3'd4;
  localparam logic [2:0] ST_RX_LOW     = 3'd5;
  localparam logic [2:0] ST_DISCARD    = 3'd6;

  logic [2:0] state;
  logic       cs_meta, cs_sync, cs_prev;
  logic       overflow;
  logic [1:0] tx_high;
  logic       rx_valid;
  logic [9:0] rx_word;

  logic       loopback;
  logic       src_valid;
  logic [9:0] src_data;
  logic       tx_busy;

`ifdef COMMAND_LOOPBACK_EN
  logic       lb_full;
  logic [9:0] lb_word;
  assign loopback  = control[7];
  assign src_valid = loopback ? lb_full : coax_rx_valid;
  assign src_data  = loopback ? lb_word : coax_rx_data;
  assign tx_busy   = loopback ? lb_full : coax_tx_valid;
`else
  assign loopback  = 1'b0;
  assign src_valid = coax_rx_valid;
  assign src_data  = coax_rx_data;
  assign tx_busy   = coax_tx_valid;
`endif

  logic       frame_end, byte_ok, do_capture, do_tx_word;
  logic [7:0] status, capture_resp;
  logic [9:0] tx_word;

  always_comb begin
    frame_end    = cs_sync & ~cs_prev;
    byte_ok      = spi_rx_strobe & ~cs_sync;
    status       = {src_valid, ~coax_tx_valid, 4'b0000, overflow, loopback};
    capture_resp = {src_valid, 5'b00000, src_valid ? src_data[9:8] : 2'b00};
    do_capture   = byte_ok & (((state == ST_COMMAND) & (spi_rx_data == 8'h06)) |
                              (state == ST_RX_LOW));
    do_tx_word   = byte_ok & (state == ST_TX_LOW);
    tx_word      = {tx_high, spi_rx_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cs_meta       <= 1'b1;
      cs_sync       <= 1'b1;
      cs_prev       <= 1'b1;
      state         <= ST_COMMAND;
      spi_tx_data   <= '0;
      spi_tx_strobe <= 1'b0;
      coax_tx_data  <= '0;
      coax_tx_valid <= 1'b0;
      coax_rx_ready <= 1'b0;
      control       <= CONTROL_DEFAULT;
      overflow      <= 1'b0;
      tx_high       <= '0;
      rx_valid      <= 1'b0;
      rx_word       <= '0;
`ifdef COMMAND_LOOPBACK_EN
      lb_full       <= 1'b0;
      lb_word       <= '0;
`endif
    end else begin
      cs_meta       <= spi_cs;
      cs_sync       <= cs_meta;
      cs_prev       <= cs_sync;
      spi_tx_strobe <= 1'b0;
      coax_rx_ready <= 1'b0;
      if (coax_tx_valid && coax_tx_ready) coax_tx_valid <= 1'b0;

      // frame end outranks a byte arriving in the same cycle
      if (frame_end) begin
        state         <= ST_COMMAND;
        spi_tx_data   <= 8'h00;
        spi_tx_strobe <= 1'b1;
      end else if (byte_ok) begin
        spi_tx_strobe <= 1'b1;
        spi_tx_data   <= 8'h00;
        case (state)
          ST_COMMAND: begin
            case (spi_rx_data)
              8'h01: begin spi_tx_data <= status; overflow <= 1'b0; state <= ST_DISCARD; end
              8'h02: begin spi_tx_data <= VERSION; state <= ST_DISCARD; end
              8'h03: begin spi_tx_data <= control; state <= ST_DISCARD; end
              8'h04: state <= ST_WR_CONTROL;
              8'h05: begin spi_tx_data <= status; state <= ST_TX_HIGH; end
              8'h06: begin spi_tx_data <= capture_resp; state <= ST_RX_HIGH; end
              default: begin spi_tx_data <= 8'hFF; state <= ST_DISCARD; end
            endcase
          end
          ST_WR_CONTROL: begin control <= spi_rx_data; state <= ST_DISCARD; end
          ST_TX_HIGH: begin
            spi_tx_data <= status;
            tx_high     <= spi_rx_data[1:0];
            state       <= ST_TX_LOW;
          end
          ST_TX_LOW: begin spi_tx_data <= status; state <= ST_TX_HIGH; end
          ST_RX_HIGH: begin
            spi_tx_data <= rx_valid ? rx_word[7:0] : 8'h00;
            state       <= ST_RX_LOW;
          end
          ST_RX_LOW: begin spi_tx_data <= capture_resp; state <= ST_RX_HIGH; end
          ST_DISCARD: state <= ST_DISCARD;
          default: state <= ST_COMMAND;
        endcase
      end

      if (do_tx_word) begin
        if (tx_busy) begin
          overflow <= 1'b1;
`ifdef COMMAND_LOOPBACK_EN
        end else if (loopback) begin
          lb_word <= tx_word;
          lb_full <= 1'b1;
`endif
        end else begin
          coax_tx_data  <= tx_word;
          coax_tx_valid <= 1'b1;
        end
      end

      if (do_capture) begin
        rx_valid <= src_valid;
        rx_word  <= src_valid ? src_data : '0;
        if (src_valid) begin
`ifdef COMMAND_LOOPBACK_EN
          if (loopback) lb_full <= 1'b0;
          else coax_rx_ready <= 1'b1;
`else
          coax_rx_ready <= 1'b1;
`endif
        end
      end

`ifdef COMMAND_LOOPBACK_EN
      // the external transmitter is silenced while looping back
      if (loopback) begin
        coax_tx_valid <= 1'b0;
        coax_tx_data  <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_spi_command_processor.sv
// Bench for spi_command_processor: frame-level reference model plus directed and random frames.
module tb_spi_command_processor;

  logic       clk = 1'b0;
  logic       reset;
  logic       spi_cs;
  logic [7:0] spi_rx_data;
  logic       spi_rx_strobe;
  logic [7:0] spi_tx_data;
  logic       spi_tx_strobe;
  logic [9:0] coax_tx_data;
  logic       coax_tx_valid;
  logic       coax_tx_ready;
  logic [9:0] coax_rx_data;
  logic       coax_rx_valid;
  logic       coax_rx_ready;
  logic [7:0] control;

  spi_command_processor #(.VERSION(8'h01), .CONTROL_DEFAULT(8'h00)) dut (
    .clk(clk), .reset(reset), .spi_cs(spi_cs), .spi_rx_data(spi_rx_data),
    .spi_rx_strobe(spi_rx_strobe), .spi_tx_data(spi_tx_data), .spi_tx_strobe(spi_tx_strobe),
    .coax_tx_data(coax_tx_data), .coax_tx_valid(coax_tx_valid), .coax_tx_ready(coax_tx_ready),
    .coax_rx_data(coax_rx_data), .coax_rx_valid(coax_rx_valid), .coax_rx_ready(coax_rx_ready),
    .control(control)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // coax receiver FIFO and transmitter ready
  logic [9:0] rxq[$];
  logic       pop_pend = 1'b0;
  logic       rand_env = 1'b0;

  always @(posedge clk) begin
    #1;
    if (pop_pend && rxq.size() > 0) rxq.delete(0);
    if (rand_env) begin
      coax_tx_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0 && rxq.size() < 4) rxq.push_back(10'($urandom_range(0, 1023)));
    end
    coax_rx_valid = (rxq.size() > 0);
    coax_rx_data  = (rxq.size() > 0) ? rxq[0] : '0;
  end

  // reference model: tracks frame position and command byte, not parser states
  logic       m_seen = 1'b0;
  logic [2:0] cs_pipe = 3'b111;
  logic [7:0] m_tx_data = '0;
  logic       m_tx_strobe = 1'b0;
  logic [9:0] m_ctx_data = '0;
  logic       m_ctx_valid = 1'b0;
  logic       m_rx_ready = 1'b0;
  logic [7:0] m_control = 8'h00;
  logic       m_ovf = 1'b0;
  int         pos = 0;
  logic [7:0] cmd = '0;
  logic [1:0] hi = '0;
  logic       cap_v = 1'b0;
  logic [9:0] cap_w = '0;

  task model_capture(output logic [7:0] r);
    cap_v = coax_rx_valid;
    cap_w = cap_v ? coax_rx_data : '0;
    if (cap_v) m_rx_ready = 1'b1;
    r = {cap_v, 5'b00000, cap_w[9:8]};
  endtask

  always @(posedge clk) begin : model
    logic       fe, acc, old_v;
    logic [7:0] st, b, r;
    if (reset) begin
      m_seen = 1'b1; cs_pipe = 3'b111; m_tx_data = '0; m_tx_strobe = 1'b0;
      m_ctx_data = '0; m_ctx_valid = 1'b0; m_rx_ready = 1'b0; m_control = 8'h00;
      m_ovf = 1'b0; pos = 0; cmd = '0;
    end else begin
      fe    = cs_pipe[1] & ~cs_pipe[2];
      acc   = spi_rx_strobe & ~cs_pipe[1] & ~fe;
      old_v = m_ctx_valid;
      st    = {coax_rx_valid, ~old_v, 4'b0000, m_ovf, 1'b0};
      m_tx_strobe = 1'b0;
      m_rx_ready  = 1'b0;
      if (old_v && coax_tx_ready) m_ctx_valid = 1'b0;
      if (fe) begin
        pos = 0; m_tx_data = 8'h00; m_tx_strobe = 1'b1;
      end else if (acc) begin
        b = spi_rx_data;
        r = 8'h00;
        if (pos == 0) begin
          cmd = b;
          case (b)
            8'h01: begin r = st; m_ovf = 1'b0; end
            8'h02: r = 8'h01;
            8'h03: r = m_control;
            8'h04: r = 8'h00;
            8'h05: r = st;
            8'h06: model_capture(r);
            default: r = 8'hFF;
          endcase
        end else begin
          case (cmd)
            8'h04: if (pos == 1) m_control = b;
            8'h05: begin
              r = st;
              if (pos % 2 == 1) hi = b[1:0];
              else if (old_v) m_ovf = 1'b1;
              else begin m_ctx_data = {hi, b}; m_ctx_valid = 1'b1; end
            end
            8'h06: if (pos % 2 == 1) r = cap_v ? cap_w[7:0] : 8'h00;
                   else model_capture(r);
            default: r = 8'h00;
          endcase
        end
        pos++;
        m_tx_data = r; m_tx_strobe = 1'b1;
      end
      cs_pipe = {cs_pipe[1:0], spi_cs};
    end
  end

  logic [7:0] resp_log[$];
  int         rx_pulses = 0;

  always @(negedge clk) begin
    pop_pend = coax_rx_ready;
    if (m_seen) begin
      chk("spi_tx_strobe", 32'(spi_tx_strobe), 32'(m_tx_strobe));
      chk("spi_tx_data",   32'(spi_tx_data),   32'(m_tx_data));
      chk("coax_tx_valid", 32'(coax_tx_valid), 32'(m_ctx_valid));
      chk("coax_tx_data",  32'(coax_tx_data),  32'(m_ctx_data));
      chk("coax_rx_ready", 32'(coax_rx_ready), 32'(m_rx_ready));
      chk("control",       32'(control),       32'(m_control));
      if (spi_tx_strobe) resp_log.push_back(spi_tx_data);
      if (coax_rx_ready) rx_pulses++;
    end
  end

  logic [7:0] fb[$];
  logic       collide = 1'b0;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    spi_rx_strobe = 1'b1; spi_rx_data = b;
    tick();
    spi_rx_strobe = 1'b0;
  endtask

  task automatic run_frame(input int gapmax);
    int g;
    resp_log.delete();
    tick();
    spi_cs = 1'b0;
    repeat (3) tick();
    foreach (fb[i]) begin
      send_byte(fb[i]);
      g = $urandom_range(0, gapmax);
      repeat (g) tick();
    end
    spi_cs = 1'b1;
    if (collide) begin
      g = $urandom_range(0, 4);
      repeat (g) tick();
      send_byte(8'($urandom_range(0, 255)));
    end
    repeat (6) tick();
  endtask

  task automatic check_log(input string name, input int idx, input logic [7:0] exp);
    chk(name, (idx < resp_log.size()) ? 32'(resp_log[idx]) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  initial begin
    int n;
    reset = 1'b1; spi_cs = 1'b1; spi_rx_data = '0; spi_rx_strobe = 1'b0;
    coax_tx_ready = 1'b0; coax_rx_valid = 1'b0; coax_rx_data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) tick();
    chk("reset_control", 32'(control), 32'h00);
    chk("reset_tx_valid", 32'(coax_tx_valid), 32'h0);

    fb = '{8'h01, 8'h00}; run_frame(2);
    check_log("status_idle", 0, 8'h40);
    check_log("status_trail", 1, 8'h00);
    check_log("frame_end_zero", 2, 8'h00);

    fb = '{8'h04, 8'hA5, 8'h03, 8'h00}; run_frame(2);
    chk("control_written", 32'(control), 32'hA5);
    fb = '{8'h03, 8'h00}; run_frame(1);
    check_log("read_control", 0, 8'hA5);
    fb = '{8'h02, 8'h00}; run_frame(1);
    check_log("read_version", 0, 8'h01);

    fb = '{8'h05, 8'h02, 8'h3C, 8'h01, 8'hFF}; run_frame(2);
    check_log("tx_cmd_status", 0, 8'h40);
    check_log("tx_low_status", 2, 8'h40);
    check_log("tx_busy_status", 3, 8'h00);
    chk("tx_word", 32'(coax_tx_data), 32'h23C);
    chk("tx_valid_held", 32'(coax_tx_valid), 32'h1);
    fb = '{8'h01, 8'h00}; run_frame(1);
    check_log("status_overflow", 0, 8'h02);
    fb = '{8'h01, 8'h00}; run_frame(1);
    check_log("overflow_cleared", 0, 8'h00);
    coax_tx_ready = 1'b1; tick(); coax_tx_ready = 1'b0; tick();
    chk("tx_valid_drop", 32'(coax_tx_valid), 32'h0);

    rxq.push_back(10'h1F0); repeat (2) tick();
    rx_pulses = 0;
    fb = '{8'h06, 8'h00, 8'h00, 8'h00}; run_frame(2);
    check_log("rx_head", 0, 8'h81);
    check_log("rx_low", 1, 8'hF0);
    check_log("rx_empty_head", 2, 8'h00);
    check_log("rx_empty_low", 3, 8'h00);
    chk("rx_pop_pulses", 32'(rx_pulses), 32'd1);

    fb = '{8'h05, 8'h03}; run_frame(1);
    chk("partial_discard", 32'(coax_tx_valid), 32'h0);
    fb = '{8'h7E, 8'h00, 8'h00}; run_frame(1);
    check_log("unknown_cmd", 0, 8'hFF);
    check_log("unknown_trail", 1, 8'h00);

    // reset mid-frame
    tick(); spi_cs = 1'b0; repeat (3) tick();
    send_byte(8'h05); send_byte(8'h01);
    reset = 1'b1; repeat (2) tick(); reset = 1'b0;
    repeat (3) tick();
    send_byte(8'h01); send_byte(8'h00);
    spi_cs = 1'b1; repeat (6) tick();
    chk("reset_midframe_tx", 32'(coax_tx_valid), 32'h0);

    rand_env = 1'b1;
    for (int f = 0; f < 250; f++) begin
      fb.delete();
      n = $urandom_range(1, 6);
      fb.push_back(($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                                : 8'($urandom_range(1, 6)));
      for (int i = 1; i < n; i++) fb.push_back(8'($urandom_range(0, 255)));
      collide = ($urandom_range(0, 2) == 0);
      run_frame(3);
    end
    rand_env = 1'b0;
    collide = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
